// File: rtl/avr_cpu_alu_seq.sv
// AVR ALU sequencer: runs 8-bit ops in one ALU pass and 16-bit ops in two
// passes through an external byte ALU, merging flags into SREG.
module avr_cpu_alu_seq #(
  parameter logic [7:0] SREG_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic        wide,
  input  logic        use_carry,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sreg_we,
  input  logic [7:0]  sreg_wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [7:0]  sreg,
  output logic [3:0]  alu_opcode,
  output logic        alu_use_carry,
  output logic [7:0]  alu_r_in,
  output logic [7:0]  alu_d_in,
  output logic [7:0]  alu_status_in,
  input  logic [7:0]  alu_out,
  input  logic [7:0]  alu_status_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_FIN
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_busy;

  logic [3:0]  r_op;
  logic        r_wide;
  logic        r_uc;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [7:0]  r_sreg;
  logic [15:0] r_result;
  logic [7:0]  r_lo_st;
  logic [7:0]  r_lo_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    w_busy        = 1'b0;
    done          = 1'b0;
    alu_opcode    = 4'h0;
    alu_use_carry = 1'b0;
    alu_r_in      = 8'h00;
    alu_d_in      = 8'h00;
    alu_status_in = r_sreg;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_LO;
        end
      end
      S_LO: begin
        w_busy        = 1'b1;
        alu_opcode    = r_op;
        alu_use_carry = r_uc;
        alu_r_in      = r_a[7:0];
        alu_d_in      = r_b[7:0];
        w_next        = r_wide ? S_HI : S_FIN;
      end
      S_HI: begin
        // High byte always chains the low byte's carry/borrow
        w_busy        = 1'b1;
        alu_opcode    = r_op;
        alu_use_carry = 1'b1;
        alu_r_in      = r_a[15:8];
        alu_d_in      = r_b[15:8];
        alu_status_in = r_lo_st;
        w_next        = S_FIN;
      end
      S_FIN: begin
        done = 1'b1;
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_LO;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign busy = w_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= 4'h0;
      r_wide   <= 1'b0;
      r_uc     <= 1'b0;
      r_a      <= 16'h0000;
      r_b      <= 16'h0000;
      r_sreg   <= SREG_RESET;
      r_result <= 16'h0000;
      r_lo_st  <= 8'h00;
      r_lo_out <= 8'h00;
    end else begin
      if (w_accept) begin
        r_op   <= op;
        r_wide <= wide;
        r_uc   <= use_carry;
        r_a    <= a;
        r_b    <= b;
      end
      if (sreg_we && !w_busy) r_sreg <= sreg_wdata;
      if (r_state == S_LO) begin
        if (r_wide) begin
          r_lo_st  <= alu_status_out;
          r_lo_out <= alu_out;
        end else begin
          r_sreg   <= alu_status_out;
          r_result <= {8'h00, alu_out};
        end
      end
      if (r_state == S_HI) begin
        // Z spans both bytes; H/T/I keep their pre-op values
        r_result <= {alu_out, r_lo_out};
        r_sreg   <= {r_sreg[7:5], alu_status_out[4:2],
                     alu_status_out[1] & r_lo_st[1],
                     alu_status_out[0]};
      end
    end
  end

  assign result = r_result;
  assign sreg   = r_sreg;

endmodule

// File: tb/tb_avr_cpu_alu_seq.sv
// Bench for avr_cpu_alu_seq with a behavioural byte ALU and a
// 16-bit reference model feeding a result/SREG scoreboard.
module tb_avr_cpu_alu_seq;

  localparam logic [7:0] SR     = 8'h40;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;

  logic        clk, rst_n, start, wide, use_carry, sreg_we;
  logic [3:0]  op;
  logic [15:0] a, b;
  logic [7:0]  sreg_wdata;
  logic        busy, done;
  logic [15:0] result;
  logic [7:0]  sreg;
  logic [3:0]  alu_opcode;
  logic        alu_use_carry;
  logic [7:0]  alu_r_in, alu_d_in, alu_status_in;
  logic [7:0]  alu_out, alu_status_out;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [23:0] sb[$];
  logic [7:0]  model_sreg;

  avr_cpu_alu_seq #(.SREG_RESET(SR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .wide(wide),
    .use_carry(use_carry), .a(a), .b(b), .sreg_we(sreg_we),
    .sreg_wdata(sreg_wdata), .busy(busy), .done(done),
    .result(result), .sreg(sreg), .alu_opcode(alu_opcode),
    .alu_use_carry(alu_use_carry), .alu_r_in(alu_r_in),
    .alu_d_in(alu_d_in), .alu_status_in(alu_status_in),
    .alu_out(alu_out), .alu_status_out(alu_status_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] t;
  logic       ci, ah, av, ac;
  always_comb begin
    ci = alu_use_carry & alu_status_in[0];
    t  = 9'd0;
    ac = alu_status_in[0];
    ah = alu_status_in[5];
    av = 1'b0;
    case (alu_opcode)
      OP_ADD: begin
        t  = {1'b0, alu_r_in} + {1'b0, alu_d_in} + {8'd0, ci};
        ac = t[8];
        ah = ({1'b0, alu_r_in[3:0]} + {1'b0, alu_d_in[3:0]}
              + {4'd0, ci}) > 5'd15;
        av = (alu_r_in[7] == alu_d_in[7]) && (t[7] != alu_r_in[7]);
      end
      OP_SUB: begin
        t  = {1'b0, alu_d_in} - {1'b0, alu_r_in} - {8'd0, ci};
        ac = t[8];
        ah = {1'b0, alu_d_in[3:0]} < ({1'b0, alu_r_in[3:0]} + {4'd0, ci});
        av = (alu_d_in[7] != alu_r_in[7]) && (t[7] != alu_d_in[7]);
      end
      OP_AND: t = {1'b0, alu_r_in & alu_d_in};
      OP_XOR: t = {1'b0, alu_r_in ^ alu_d_in};
      default: t = 9'd0;
    endcase
    alu_out        = t[7:0];
    alu_status_out = {alu_status_in[7:6], ah, t[7] ^ av, av, t[7],
                      t[7:0] == 8'd0, ac};
  end

  // Whole-word reference: {result, sreg}
  function automatic logic [23:0] ref_op(input logic [3:0] o,
      input logic w, input logic uc, input logic [15:0] x,
      input logic [15:0] y, input logic [7:0] s);
    logic [31:0] m, xa, ya, full, r;
    logic        c, h, v, n, z, cin, xs, ys, rs;
    logic [7:0]  ns;
    int          top;
    top  = w ? 15 : 7;
    m    = w ? 32'hFFFF : 32'hFF;
    xa   = {16'd0, x} & m;
    ya   = {16'd0, y} & m;
    cin  = uc & s[0];
    c    = s[0];
    h    = s[5];
    v    = 1'b0;
    full = 32'd0;
    xs   = xa[top];
    ys   = ya[top];
    case (o)
      OP_ADD: begin
        full = xa + ya + {31'd0, cin};
        c    = full[w ? 16 : 8];
        if (!w) h = ((xa & 32'd15) + (ya & 32'd15) + {31'd0, cin}) > 32'd15;
      end
      OP_SUB: begin
        full = ya - xa - {31'd0, cin};
        c    = ya < (xa + {31'd0, cin});
        if (!w) h = (ya & 32'd15) < ((xa & 32'd15) + {31'd0, cin});
      end
      OP_AND: full = xa & ya;
      default: full = xa ^ ya;
    endcase
    r  = full & m;
    rs = r[top];
    if (o == OP_ADD) v = (xs == ys) && (rs != xs);
    if (o == OP_SUB) v = (xs != ys) && (rs != ys);
    n  = rs;
    z  = (r == 32'd0);
    ns = w ? {s[7:5], n ^ v, v, n, z, c} : {s[7:6], h, n ^ v, v, n, z, c};
    return {r[15:0], ns};
  endfunction

  task automatic do_op(input logic [3:0] o, input logic w, input logic uc,
      input logic [15:0] x, input logic [15:0] y, input logic wr,
      input logic [7:0] wd, input logic poke, output int lat,
      output int busy_n, output logic [15:0] res, output logic [7:0] sr,
      output logic [7:0] lo_r, output logic [7:0] hi_r, output logic hi_uc);
    logic [23:0] e;
    @(negedge clk);
    if (wr) model_sreg = wd;
    e = ref_op(o, w, uc, x, y, model_sreg);
    model_sreg = e[7:0];
    sb.push_back(e);
    op = o; wide = w; use_carry = uc; a = x; b = y;
    start = 1'b1; sreg_we = wr; sreg_wdata = wd;
    lat = 0; busy_n = 0; lo_r = 8'h00; hi_r = 8'h00; hi_uc = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      start = 1'b0; sreg_we = 1'b0;
      a = 16'($urandom); b = 16'($urandom);
      op = 4'($urandom_range(0, 3)); wide = ~w; use_carry = ~uc;
      if (busy) busy_n++;
      if (lat == 1) lo_r = alu_r_in;
      if (lat == 2) begin hi_r = alu_r_in; hi_uc = alu_use_carry; end
      if (poke && lat == 1) begin sreg_we = 1'b1; sreg_wdata = 8'h3F; end
    end while (!done && lat < 8);
    res = result;
    sr  = sreg;
  endtask

  int          lat, bn;
  logic [15:0] res;
  logic [7:0]  sr, lo_r, hi_r;
  logic        hi_uc;
  logic [23:0] e;

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 4'h0; wide = 1'b0; use_carry = 1'b0;
    a = 16'h0; b = 16'h0; sreg_we = 1'b0; sreg_wdata = 8'h00;
    model_sreg = SR;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, result, sreg} !== {1'b0, 1'b0, 16'h0000, SR}) begin
      n_err++;
      $display("FAIL reset_state got %b %b %h %h want 0 0 0000 %h",
               busy, done, result, sreg, SR);
    end
    n_cmp++;
    if ({alu_opcode, alu_use_carry, alu_r_in, alu_d_in, alu_status_in}
        !== {4'h0, 1'b0, 8'h00, 8'h00, SR}) begin
      n_err++;
      $display("FAIL reset_alu_drive got %h %b %h %h %h want 0 0 00 00 %h",
               alu_opcode, alu_use_carry, alu_r_in, alu_d_in,
               alu_status_in, SR);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_byte_add();
    do_op(OP_ADD, 1'b0, 1'b0, 16'd40, 16'd50, 1'b0, 8'h00, 1'b0,
          lat, bn, res, sr, lo_r, hi_r, hi_uc);
    e = sb.pop_front();
    n_cmp++;
    if ({res, sr} !== e) begin
      n_err++; $display("FAIL byte_add_sb got %h want %h", {res, sr}, e);
    end
    n_cmp++;
    if ({res, sr[1:0]} !== {16'h005A, 2'b00}) begin
      n_err++; $display("FAIL byte_add_const got %h/%b want 005a/00",
                        res, sr[1:0]);
    end
    n_cmp++;
    if ({lat, bn} !== {32'd2, 32'd1}) begin
      n_err++; $display("FAIL byte_latency got lat=%0d busy=%0d want 2/1",
                        lat, bn);
    end
  endtask

  task automatic test_carry();
    do_op(OP_ADD, 1'b0, 1'b0, 16'd40, 16'd240, 1'b0, 8'h00, 1'b0,
          lat, bn, res, sr, lo_r, hi_r, hi_uc);
    e = sb.pop_front();
    n_cmp++;
    if ({res, sr} !== e || res !== 16'h0018 || sr[0] !== 1'b1) begin
      n_err++; $display("FAIL carry_out got %h want %h", {res, sr}, e);
    end
    do_op(OP_ADD, 1'b0, 1'b1, 16'd0, 16'd0, 1'b0, 8'h00, 1'b0,
          lat, bn, res, sr, lo_r, hi_r, hi_uc);
    e = sb.pop_front();
    n_cmp++;
    if ({res, sr} !== e || res !== 16'h0001) begin
      n_err++; $display("FAIL carry_in got %h want %h", {res, sr}, e);
    end
  endtask

  task automatic test_wide_add();
    do_op(OP_ADD, 1'b1, 1'b0, 16'h00FF, 16'h0001, 1'b0, 8'h00, 1'b0,
          lat, bn, res, sr, lo_r, hi_r, hi_uc);
    e = sb.pop_front();
    n_cmp++;
    if ({res, sr} !== e || res !== 16'h0100 || sr[1:0] !== 2'b00) begin
      n_err++; $display("FAIL wide_add got %h want %h", {res, sr}, e);
    end
    n_cmp++;
    if ({lat, bn} !== {32'd3, 32'd2}) begin
      n_err++; $display("FAIL wide_latency got lat=%0d busy=%0d want 3/2",
                        lat, bn);
    end
    n_cmp++;
    if ({lo_r, hi_r, hi_uc} !== {8'hFF, 8'h00, 1'b1}) begin
      n_err++; $display("FAIL wide_alu_drive got %h %h %b want ff 00 1",
                        lo_r, hi_r, hi_uc);
    end
  endtask

  task automatic test_wide_xor_busy();
    int pulses;
    @(negedge clk);
    e = ref_op(OP_XOR, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, model_sreg);
    model_sreg = e[7:0];
    sb.push_back(e);
    op = OP_XOR; wide = 1'b1; use_carry = 1'b0;
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    pulses = 0; res = 16'hDEAD; sr = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      start = (i == 1 || i == 2);
      op = OP_ADD; wide = 1'b0; a = 16'h1234; b = 16'h0101;
      if (done) begin
        pulses++;
        if (pulses == 1) begin res = result; sr = sreg; end
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if ({res, sr} !== e || res !== 16'h0000 || sr[1] !== 1'b1) begin
      n_err++; $display("FAIL wide_xor got %h want %h", {res, sr}, e);
    end
    n_cmp++;
    if (pulses !== 1) begin
      n_err++; $display("FAIL busy_ignore got %0d done pulses want 1", pulses);
    end
  endtask

  task automatic test_sreg_write();
    @(negedge clk);
    sreg_we = 1'b1; sreg_wdata = 8'h80;
    @(negedge clk);
    sreg_we = 1'b0;
    model_sreg = 8'h80;
    n_cmp++;
    if (sreg !== 8'h80) begin
      n_err++; $display("FAIL sreg_write got %h want 80", sreg);
    end
    do_op(OP_ADD, 1'b0, 1'b0, 16'd1, 16'd2, 1'b0, 8'h00, 1'b1,
          lat, bn, res, sr, lo_r, hi_r, hi_uc);
    e = sb.pop_front();
    n_cmp++;
    if ({res, sr} !== e || sr !== 8'h80) begin
      n_err++; $display("FAIL sreg_keep_i got %h want %h", {res, sr}, e);
    end
    do_op(OP_ADD, 1'b0, 1'b1, 16'd0, 16'd0, 1'b1, 8'h01, 1'b0,
          lat, bn, res, sr, lo_r, hi_r, hi_uc);
    e = sb.pop_front();
    n_cmp++;
    if ({res, sr} !== e || res !== 16'h0001) begin
      n_err++; $display("FAIL sreg_write_first got %h want %h", {res, sr}, e);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    e = ref_op(OP_ADD, 1'b0, 1'b0, 16'd3, 16'd4, model_sreg);
    model_sreg = e[7:0];
    sb.push_back(e);
    op = OP_ADD; wide = 1'b0; use_carry = 1'b0; a = 16'd3; b = 16'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++;
    if ({done, result, sreg} !== {1'b1, e}) begin
      n_err++; $display("FAIL b2b_first got %b %h want 1 %h",
                        done, {result, sreg}, e);
    end
    e = ref_op(OP_SUB, 1'b1, 1'b0, 16'h0001, 16'h1000, model_sreg);
    model_sreg = e[7:0];
    sb.push_back(e);
    op = OP_SUB; wide = 1'b1; a = 16'h0001; b = 16'h1000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({done, busy} !== 2'b01) begin
      n_err++; $display("FAIL b2b_pulse got done=%b busy=%b want 0 1",
                        done, busy);
    end
    lat = 1;
    while (!done && lat < 8) begin @(negedge clk); lat++; end
    e = sb.pop_front();
    n_cmp++;
    if ({result, sreg} !== e || result !== 16'h0FFF || lat !== 3) begin
      n_err++; $display("FAIL b2b_second got %h lat=%0d want %h lat=3",
                        {result, sreg}, lat, e);
    end
  endtask

  task automatic test_random();
    logic [3:0]  ro;
    logic        rw, ru;
    logic [15:0] rx, ry;
    for (int k = 0; k < 24; k++) begin
      ro = 4'($urandom_range(0, 3));
      rw = 1'($urandom);
      ru = 1'($urandom);
      rx = 16'($urandom);
      ry = 16'($urandom);
      do_op(ro, rw, ru, rx, ry, 1'b0, 8'h00, 1'b0,
            lat, bn, res, sr, lo_r, hi_r, hi_uc);
      e = sb.pop_front();
      n_cmp++;
      if ({res, sr} !== e || lat !== (rw ? 3 : 2)) begin
        n_err++;
        $display("FAIL random_%0d op=%0d w=%b got %h lat=%0d want %h",
                 k, ro, rw, {res, sr}, lat, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    op = OP_ADD; wide = 1'b1; use_carry = 1'b0;
    a = 16'h1111; b = 16'h2222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_hi got busy=%b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    model_sreg = SR;
    n_cmp++;
    if ({busy, done, result, sreg, alu_opcode}
        !== {1'b0, 1'b0, 16'h0000, SR, 4'h0}) begin
      n_err++;
      $display("FAIL reset_mid got %b %b %h %h %h want 0 0 0000 %h 0",
               busy, done, result, sreg, alu_opcode, SR);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_err++; $display("FAIL reset_mid_nodone got %0d pulses want 0", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_byte_add();
    test_carry();
    test_wide_add();
    test_wide_xor_busy();
    test_sreg_write();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
